mem_port_sched: RTL and testbench

MEM_PORT_SCHED -- requirements
Module: mem_port_sched

---
 rtl/mem_port_sched.sv | 120 ++++++++++++
 tb/tb_mem_port_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sched.sv
// Two-requester (fetch, load/store) scheduler onto one memory port; one transaction in flight, 3-cycle minimum.
// Memory grant stalls hold the issued request; a missing response is answered with an error after TIMEOUT cycles.
module mem_port_sched #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_e;

  state_e          state;
  logic            owner_ls;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            lat_we;
  logic [3:0]      lat_be;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic            starve_hit, sel_if, tmo_hit;
  logic            issue, rsp_ok, rsp_err, rsp_any;

  assign starve_hit = (starve_cnt == SW'(STARVE_MAX));
  assign sel_if     = if_req_i && (!ls_req_i || starve_hit);
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner_ls   <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req_i || ls_req_i) begin
            state    <= ISSUE;
            owner_ls <= !sel_if;
            if (sel_if) begin
              lat_we     <= 1'b0;
              lat_be     <= 4'hF;
              lat_addr   <= if_addr_i;
              lat_wdata  <= '0;
              starve_cnt <= '0;
            end else begin
              lat_we    <= ls_we_i;
              lat_be    <= ls_be_i;
              lat_addr  <= ls_addr_i;
              lat_wdata <= ls_wdata_i;
              if (if_req_i && !starve_hit) starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          if (mem_gnt_i) begin
            state   <= WAIT;
            tmo_cnt <= '0;
          end
        end
        WAIT: begin
          if (mem_rvalid_i || tmo_hit) state <= IDLE;
          else                         tmo_cnt <= tmo_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are masked during reset so an aborted transaction can never complete.
  assign issue   = (state == ISSUE) && !rst_i;
  assign rsp_ok  = (state == WAIT) && mem_rvalid_i && !rst_i;
  assign rsp_err = (state == WAIT) && !mem_rvalid_i && tmo_hit && !rst_i;
  assign rsp_any = rsp_ok || rsp_err;

  assign mem_req_o   = issue;
  assign mem_we_o    = issue && lat_we;
  assign mem_be_o    = issue ? lat_be    : '0;
  assign mem_addr_o  = issue ? lat_addr  : '0;
  assign mem_wdata_o = issue ? lat_wdata : '0;

  assign if_gnt_o    = issue && mem_gnt_i && !owner_ls;
  assign if_rvalid_o = rsp_any && !owner_ls;
  assign if_err_o    = rsp_err && !owner_ls;
  assign if_rdata_o  = (rsp_ok && !owner_ls) ? mem_rdata_i : '0;

  assign ls_gnt_o    = issue && mem_gnt_i && owner_ls;
  assign ls_rvalid_o = rsp_any && owner_ls;
  assign ls_err_o    = rsp_err && owner_ls;
  assign ls_rdata_o  = (rsp_ok && owner_ls) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched: per-cycle vector table plus starvation, timeout and reset sequences.
module tb_mem_port_sched;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i, ls_req_i, ls_we_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i, mem_rdata_i;
  logic [3:0]  ls_be_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o, ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] if_rdata_o, ls_rdata_o, mem_addr_o, mem_wdata_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic rst; logic if_req; logic [31:0] if_addr;
    logic ls_req; logic ls_we; logic [3:0] ls_be; logic [31:0] ls_addr; logic [31:0] ls_wdata;
    logic gnt; logic rvalid; logic [31:0] rdata;
  } in_t;

  typedef struct packed {
    logic mem_req; logic mem_we; logic [3:0] mem_be; logic [31:0] mem_addr; logic [31:0] mem_wdata;
    logic if_gnt; logic if_rvalid; logic [31:0] if_rdata; logic if_err;
    logic ls_gnt; logic ls_rvalid; logic [31:0] ls_rdata; logic ls_err;
  } out_t;

  typedef struct {
    string nm;
    in_t   i;
    out_t  o;
  } vec_t;

  out_t act;
  assign act = {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
                ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o};

  mem_port_sched #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(input logic rst, input logic ifr, input logic [31:0] ifa,
                                input logic lsr, input logic we, input logic [3:0] be,
                                input logic [31:0] lsa, input logic [31:0] wd,
                                input logic g, input logic rv, input logic [31:0] rd);
    mk_in = {rst, ifr, ifa, lsr, we, be, lsa, wd, g, rv, rd};
  endfunction

  function automatic out_t mk_out(input logic mreq, input logic mwe, input logic [3:0] mbe,
                                  input logic [31:0] maddr, input logic [31:0] mwd,
                                  input logic ig, input logic irv, input logic [31:0] ird, input logic ie,
                                  input logic lg, input logic lrv, input logic [31:0] lrd, input logic le);
    mk_out = {mreq, mwe, mbe, maddr, mwd, ig, irv, ird, ie, lg, lrv, lrd, le};
  endfunction

  task automatic drive(input in_t v);
    rst_i = v.rst; if_req_i = v.if_req; if_addr_i = v.if_addr;
    ls_req_i = v.ls_req; ls_we_i = v.ls_we; ls_be_i = v.ls_be;
    ls_addr_i = v.ls_addr; ls_wdata_i = v.ls_wdata;
    mem_gnt_i = v.gnt; mem_rvalid_i = v.rvalid; mem_rdata_i = v.rdata;
  endtask

  task automatic chk(input string nm, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  vec_t vecs[$];
  int   order[$];
  int   exp_order[11] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1, 2};
  int   early_hits;

  task automatic addv(input string nm, input in_t i, input out_t o);
    vec_t v;
    v.nm = nm; v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  initial begin
    drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    addv("reset",        mk_in(1, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0), '0);
    addv("after_reset",  mk_in(0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0), '0);
    addv("f_idle",       mk_in(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0), '0);
    addv("f_issue",      mk_in(0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0),
                         mk_out(1, 0, 4'hF, 32'h100, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    addv("f_rsp",        mk_in(0, 0, 0,      0, 0, 0, 0, 0, 0, 1, 32'h13),
                         mk_out(0, 0, 0, 0, 0, 0, 1, 32'h13, 0, 0, 0, 0, 0));
    addv("stray_idle",   mk_in(0, 0, 0,      0, 0, 0, 0, 0, 0, 1, 32'h55), '0);
    addv("stray_after",  mk_in(0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0), '0);
    addv("st_idle",      mk_in(0, 0, 0, 1, 1, 4'h3, 32'h2000, 32'hDEADBEEF, 0, 0, 0), '0);
    for (int k = 1; k <= 3; k++)
      addv($sformatf("st_stall%0d", k), mk_in(0, 0, 0, 1, 1, 4'h3, 32'h2000, 32'hDEADBEEF, 0, 0, 0),
           mk_out(1, 1, 4'h3, 32'h2000, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0));
    addv("st_gnt",       mk_in(0, 0, 0, 1, 1, 4'h3, 32'h2000, 32'hDEADBEEF, 1, 0, 0),
                         mk_out(1, 1, 4'h3, 32'h2000, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0, 0));
    addv("st_wait",      mk_in(0, 0, 0, 0, 0, 4'hC, 32'h9999, 32'h1111, 0, 0, 0), '0);
    addv("st_rsp",       mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),
                         mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    addv("st_done",      mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), '0);
    addv("ld_idle",      mk_in(0, 0, 0, 1, 0, 4'hF, 32'h3000, 0, 0, 0, 0), '0);
    addv("ld_issue",     mk_in(0, 0, 0, 1, 0, 4'hF, 32'h3000, 0, 1, 0, 0),
                         mk_out(1, 0, 4'hF, 32'h3000, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    addv("ld_rsp",       mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5),
                         mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 0));

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].i);
      #1;
      chk(vecs[n].nm, act, vecs[n].o);
    end

    // Both requesters held with an always-ready memory: 11 transactions of 3 cycles each.
    @(negedge clk);
    drive(mk_in(0, 1, 32'h700, 1, 0, 4'hF, 32'h800, 0, 1, 1, 32'h1));
    for (int c = 0; c < 33; c++) begin
      #1;
      if (if_gnt_o && ls_gnt_o) chk("starve_both_gnt", 1, 0);
      if (if_gnt_o) order.push_back(1);
      if (ls_gnt_o) order.push_back(2);
      @(negedge clk);
    end
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("starve_count", order.size(), 11);
    for (int k = 0; k < 11 && k < order.size(); k++)
      chk($sformatf("starve_order%0d", k), order[k], exp_order[k]);

    // LS read timeout; starve_cnt is 1 here (last grant was LS with fetch pending).
    @(negedge clk);
    drive(mk_in(0, 0, 0, 1, 0, 4'hF, 32'h4000, 0, 0, 0, 32'hFFFFFFFF));
    @(negedge clk);
    mem_gnt_i = 1'b1;
    #1;
    chk("tmo_gnt", {ls_gnt_o, if_gnt_o, mem_addr_o}, {1'b1, 1'b0, 32'h4000});
    early_hits = 0;
    for (int w = 1; w <= 16; w++) begin
      @(negedge clk);
      ls_req_i = 1'b0; mem_gnt_i = 1'b0;
      #1;
      if (w < 16) begin
        if (ls_rvalid_o || ls_err_o || if_rvalid_o) early_hits++;
      end else begin
        chk("tmo_early", early_hits, 0);
        chk("tmo_rsp", {ls_rvalid_o, ls_err_o, ls_rdata_o, if_rvalid_o}, {1'b1, 1'b1, 32'h0, 1'b0});
      end
    end
    @(negedge clk);
    mem_rdata_i = '0;
    #1;
    chk("tmo_idle", act, '0);
    chk("tmo_starve", dut.starve_cnt, 1);

    // Reset while an LS read is in WAIT with a nonzero starve counter.
    @(negedge clk);
    drive(mk_in(0, 1, 32'h600, 1, 0, 4'hF, 32'h6000, 0, 0, 0, 0));
    @(negedge clk);
    mem_gnt_i = 1'b1;
    #1;
    chk("rls_gnt", {ls_gnt_o, if_gnt_o}, 2'b10);
    @(negedge clk);
    drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rls_starve_pre", dut.starve_cnt, 2);
    @(negedge clk);
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77));
    #1;
    chk("rls_no_rsp", act, '0);
    chk("rls_starve_post", dut.starve_cnt, 0);

    // Reset while a fetch is in WAIT, response arriving with and after reset.
    @(negedge clk);
    drive(mk_in(0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    mem_gnt_i = 1'b1;
    #1;
    chk("rif_gnt", {if_gnt_o, mem_req_o, mem_addr_o}, {1'b1, 1'b1, 32'h500});
    @(negedge clk);
    drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99));
    #1;
    chk("rif_in_reset", act, '0);
    @(negedge clk);
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99));
    #1;
    chk("rif_after_reset", act, '0);
    @(negedge clk);
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rif_idle", act, '0);
    chk("rif_starve", dut.starve_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
